// File: rtl/seq_ctrl_pkg.sv
// Shared types, constants and toggle function for the 3-bit T-flip-flop
// sequence counter (cycle 5, 2, 7, 0, 3, 1, 6, back to 5).
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic [2:0] SEQ_FIRST   = 3'd5;
  localparam logic [2:0] SEQ_LAST    = 3'd6;
  localparam logic [2:0] SEQ_ILLEGAL = 3'd4;

  // Per-bit toggle enables {Ta,Tb,Tc}; bit 2 = A, bit 1 = B, bit 0 = C.
  function automatic logic [2:0] seq_toggles(input logic [2:0] v);
    logic a, b, c;
    logic ta, tb, tc;
    a  = v[2];
    b  = v[1];
    c  = v[0];
    ta = (~b & c) | (a & c) | (~a & b & ~c);
    tb = a | ~b | c;
    tc = a | ~b | ~c;
    return {ta, tb, tc};
  endfunction

endpackage

// File: rtl/seq_counter_ctrl_if.sv
// Command/status bundle between a requester and seq_counter_ctrl.
// Optional macro: SEQ_CTRL_ILLEGAL_DET_EN adds the sticky err status line.
interface seq_counter_ctrl_if #(
  parameter int STEPS_W = 8
);
  logic               start;
  logic [2:0]         seed;
  logic [STEPS_W-1:0] steps;
  logic               hold;
  logic               abort;
  logic [2:0]         count;
  logic               busy;
  logic               done;
  logic               wrap;
`ifdef SEQ_CTRL_ILLEGAL_DET_EN
  logic               err;

  modport master (
    output start, seed, steps, hold, abort,
    input  count, busy, done, wrap, err
  );

  modport slave (
    input  start, seed, steps, hold, abort,
    output count, busy, done, wrap, err
  );
`else
  modport master (
    output start, seed, steps, hold, abort,
    input  count, busy, done, wrap
  );

  modport slave (
    input  start, seed, steps, hold, abort,
    output count, busy, done, wrap
  );
`endif
endinterface

// File: rtl/seq_tff_datapath.sv
// Three T flip-flops stepping through the fixed sequence, with parallel
// load and advance enable. wrap is registered with the 6 -> 5 advance.
// Optional macro: SEQ_CTRL_ILLEGAL_DET_EN forces value 4 to advance to 5.
module seq_tff_datapath
  import seq_ctrl_pkg::*;
#(
  parameter logic [2:0] RST_VAL = 3'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       adv,
  output logic [2:0] count,
  output logic       wrap
);

  logic [2:0] tog;

  // Toggle vector for the current value; 4 is steered back onto the cycle
  // only when illegal-state recovery is built in.
  always_comb begin
    tog = seq_toggles(count);
`ifdef SEQ_CTRL_ILLEGAL_DET_EN
    if (count == SEQ_ILLEGAL) begin
      tog = count ^ SEQ_FIRST;
    end
`endif
  end

  // T flip-flops: load has priority over advance; wrap marks the 6 -> 5 step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_VAL;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count <= load_val;
      end else if (adv) begin
        count <= count ^ tog;
        wrap  <= (count == SEQ_LAST);
      end
    end
  end

endmodule

// File: rtl/seq_counter_ctrl.sv
// Sequence counter controller: accepts a start/seed/steps command, advances
// the T-flip-flop datapath that many times (with hold/abort) and pulses done.
// Optional macro: SEQ_CTRL_ILLEGAL_DET_EN enables illegal-value (4)
// substitution and the sticky err flag.
//
// state | meaning
// IDLE  | waiting for start; count held
// RUN   | advancing once per cycle unless held; abort returns to IDLE
// DONE  | single-cycle completion pulse, then back to IDLE
module seq_counter_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int         STEPS_W = 8,
  parameter logic [2:0] RST_VAL = 3'd5
) (
  input logic               clk,
  input logic               rst,
  seq_counter_ctrl_if.slave bus
);

  localparam logic [STEPS_W-1:0] REM_ONE = STEPS_W'(1);

  seq_state_t         state_q, state_d;
  logic [STEPS_W-1:0] rem_q, rem_d;
  logic               load;
  logic               adv;
  logic [2:0]         load_val;
  logic [2:0]         count_w;
  logic               wrap_w;

  // Seed 4 is only remapped when illegal-state recovery is built in.
`ifdef SEQ_CTRL_ILLEGAL_DET_EN
  assign load_val = (bus.seed == SEQ_ILLEGAL) ? SEQ_FIRST : bus.seed;
`else
  assign load_val = bus.seed;
`endif

  // Next-state, remaining-steps and datapath control.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          rem_d   = bus.steps;
          state_d = (bus.steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.hold) begin
          adv   = 1'b1;
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and remaining-steps registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef SEQ_CTRL_ILLEGAL_DET_EN
  logic err_q;

  // Sticky flag: set by a seed of 4 or by advancing out of 4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((load && bus.seed == SEQ_ILLEGAL) ||
                 (adv && count_w == SEQ_ILLEGAL)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`endif

  seq_tff_datapath #(
    .RST_VAL (RST_VAL)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .adv      (adv),
    .count    (count_w),
    .wrap     (wrap_w)
  );

  assign bus.count = count_w;
  assign bus.wrap  = wrap_w;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Scoreboard bench for seq_counter_ctrl: the driver computes expected
// per-cycle outputs from the sequence table and queues them; a monitor
// pops one entry after every rising edge and compares.
module tb_seq_counter_ctrl;

  localparam int STEPS_W = 8;

  typedef struct {
    logic [2:0] cnt;
    bit         busy;
    bit         done;
    bit         wrap;
    bit         err;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  bit   mon_en;
  int   vectors;
  int   fails;
  logic [2:0] exp_cnt;
  bit   exp_err;

  seq_counter_ctrl_if #(.STEPS_W(STEPS_W)) bus ();

  seq_counter_ctrl #(
    .STEPS_W (STEPS_W),
    .RST_VAL (3'd5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference successor from the published cycle; 4 is off-cycle.
  function automatic logic [2:0] next_val(input logic [2:0] v);
    logic [2:0] cyc [7];
    logic [2:0] r;
    cyc = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd3, 3'd1, 3'd6};
`ifdef SEQ_CTRL_ILLEGAL_DET_EN
    r = 3'd5;
`else
    r = 3'd7;
`endif
    for (int i = 0; i < 7; i++) begin
      if (cyc[i] == v) r = cyc[(i + 1) % 7];
    end
    return r;
  endfunction

  // One cycle of stimulus plus the expected outputs after the next edge.
  task automatic step(input bit st, input logic [2:0] sd, input int n,
                      input bit hd, input bit ab,
                      input logic [2:0] e_cnt, input bit e_busy,
                      input bit e_done, input bit e_wrap);
    exp_t e;
    @(negedge clk);
    bus.start = st;
    bus.seed  = sd;
    bus.steps = STEPS_W'(n);
    bus.hold  = hd;
    bus.abort = ab;
    e.cnt  = e_cnt;
    e.busy = e_busy;
    e.done = e_done;
    e.wrap = e_wrap;
    e.err  = exp_err;
    q.push_back(e);
  endtask

  task automatic idle_cycle();
    step(1'b0, 3'($urandom_range(7)), int'($urandom_range(255)),
         1'($urandom_range(1)), 1'($urandom_range(1)),
         exp_cnt, 1'b0, 1'b0, 1'b0);
  endtask

  // One command: start, RUN cycles (with hold / optional abort), DONE.
  task automatic run_txn(input logic [2:0] sd, input int n, input int hold_pct,
                         input int hold_from, input int hold_len, input int abort_at);
    int  left;
    int  c;
    bit  hd;
    bit  ab;
    bit  w;
    exp_cnt = sd;
`ifdef SEQ_CTRL_ILLEGAL_DET_EN
    if (sd == 3'd4) begin
      exp_cnt = 3'd5;
      exp_err = 1'b1;
    end
`endif
    step(1'b1, sd, n, 1'($urandom_range(1)), 1'($urandom_range(1)),
         exp_cnt, 1'b1, (n == 0), 1'b0);
    left = n;
    c    = 0;
    while (left > 0) begin
      hd = ((c >= hold_from) && (c < hold_from + hold_len)) ||
           (int'($urandom_range(99)) < hold_pct);
      ab = (c == abort_at);
      if (ab) begin
        step(1'($urandom_range(1)), 3'($urandom_range(7)), int'($urandom_range(255)),
             hd, 1'b1, exp_cnt, 1'b0, 1'b0, 1'b0);
        return;
      end else if (hd) begin
        step(1'($urandom_range(1)), 3'($urandom_range(7)), int'($urandom_range(255)),
             1'b1, 1'b0, exp_cnt, 1'b1, 1'b0, 1'b0);
      end else begin
        w = (exp_cnt == 3'd6);
`ifdef SEQ_CTRL_ILLEGAL_DET_EN
        if (exp_cnt == 3'd4) exp_err = 1'b1;
`endif
        exp_cnt = next_val(exp_cnt);
        left--;
        step(1'($urandom_range(1)), 3'($urandom_range(7)), int'($urandom_range(255)),
             1'b0, 1'b0, exp_cnt, 1'b1, (left == 0), w);
      end
      c++;
    end
    step(1'($urandom_range(1)), 3'($urandom_range(7)), int'($urandom_range(255)),
         1'($urandom_range(1)), 1'($urandom_range(1)), exp_cnt, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare one queued expectation after each rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        check("count", int'(bus.count), int'(e.cnt));
        check("busy",  int'(bus.busy),  int'(e.busy));
        check("done",  int'(bus.done),  int'(e.done));
        check("wrap",  int'(bus.wrap),  int'(e.wrap));
`ifdef SEQ_CTRL_ILLEGAL_DET_EN
        check("err",   int'(bus.err),   int'(e.err));
`endif
      end else begin
        check("unexpected_done", int'(bus.done), 0);
      end
    end
  end

  initial begin
    int n;
    int ab_at;
    vectors   = 0;
    fails     = 0;
    mon_en    = 1'b0;
    exp_err   = 1'b0;
    exp_cnt   = 3'd5;
    bus.start = 1'b0;
    bus.seed  = 3'd0;
    bus.steps = '0;
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b1;
    #12;
    check("rst_count", int'(bus.count), 5);
    check("rst_busy",  int'(bus.busy),  0);
    check("rst_done",  int'(bus.done),  0);
    check("rst_wrap",  int'(bus.wrap),  0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle_cycle();

    run_txn(3'd5, 7, 0, -1, 0, -1);
    run_txn(3'd3, 0, 0, -1, 0, -1);
    idle_cycle();
    run_txn(3'd0, 4, 0, 2, 2, -1);
    run_txn(3'd0, 5, 0, -1, 0, 2);
    run_txn(3'd2, 3, 0, -1, 0, -1);
    run_txn(3'd4, 1, 0, -1, 0, -1);
    idle_cycle();
    run_txn(3'd1, 255, 0, -1, 0, -1);

    // Asynchronous reset while running with count = 7.
    step(1'b1, 3'd5, 7, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("midrst_count", int'(bus.count), 5);
    check("midrst_busy",  int'(bus.busy),  0);
    check("midrst_done",  int'(bus.done),  0);
`ifdef SEQ_CTRL_ILLEGAL_DET_EN
    check("midrst_err",   int'(bus.err),   0);
`endif
    q.delete();
    exp_cnt = 3'd5;
    exp_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle_cycle();

    for (int t = 0; t < 60; t++) begin
      n     = ($urandom_range(9) == 0) ? int'($urandom_range(40)) : int'($urandom_range(10));
      ab_at = ($urandom_range(5) == 0) ? int'($urandom_range(n)) : -1;
      run_txn(3'($urandom_range(7)), n, 25, -1, 0, ab_at);
      for (int g = 0; g < int'($urandom_range(2)); g++) idle_cycle();
    end

    idle_cycle();
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
